// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned radix-2 shift-add datapath: start loads magnitudes, each step adds and shifts.
module seq_mult_core
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       step,
    input  logic [WIDTH_A-1:0]         a_mag,
    input  logic [WIDTH_B-1:0]         b_mag,
    output logic [WIDTH_A+WIDTH_B-1:0] acc_next
);

    localparam int unsigned PW = WIDTH_A + WIDTH_B;

    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH_B-1:0] mplier_q, mplier_d;

    // Exposed so the final step's addition is visible on the same edge it is committed.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH_B{1'b0}}, a_mag};
            mplier_d = b_mag;
        end else if (step) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_multiplier_hs.sv
// Handshaked sequential multiplier with signed/unsigned mode and fixed WIDTH_B-step latency.
// Optional accumulate-into-product feature enabled by defining SEQ_MULT_ACC_EN.
module seq_multiplier_hs
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_signed,
`ifdef SEQ_MULT_ACC_EN
    input  logic                       in_acc,
`endif
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy
);

    localparam int unsigned PW   = WIDTH_A + WIDTH_B;
    localparam int unsigned CntW = (clog2(WIDTH_B) < 1) ? 1 : clog2(WIDTH_B);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH_B - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     product_q, product_d;
    logic [WIDTH_A-1:0] a_mag;
    logic [WIDTH_B-1:0] b_mag;
    logic              core_start, core_step;
    logic [PW-1:0]     acc_next, result;
`ifdef SEQ_MULT_ACC_EN
    logic              acc_en_q, acc_en_d;
`endif

    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    assign a_mag  = (in_signed && a[WIDTH_A-1]) ? -a : a;
    assign b_mag  = (in_signed && b[WIDTH_B-1]) ? -b : b;
    assign result = neg_q ? -acc_next : acc_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        product_d  = product_q;
        core_start = 1'b0;
        core_step  = 1'b0;
`ifdef SEQ_MULT_ACC_EN
        acc_en_d   = acc_en_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    neg_d      = in_signed & (a[WIDTH_A-1] ^ b[WIDTH_B-1]);
                    core_start = 1'b1;
`ifdef SEQ_MULT_ACC_EN
                    acc_en_d   = in_acc;
`endif
                end
            end
            StRun: begin
                core_step = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cnt_d   = '0;
`ifdef SEQ_MULT_ACC_EN
                    product_d = acc_en_q ? product_q + result : result;
`else
                    product_d = result;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
`ifdef SEQ_MULT_ACC_EN
            acc_en_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
`ifdef SEQ_MULT_ACC_EN
            acc_en_q  <= acc_en_d;
`endif
        end
    end

    seq_mult_core #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .step     (core_step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next)
    );

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Directed self-checking bench for seq_multiplier_hs at WIDTH_A = WIDTH_B = 8.
module tb_seq_multiplier_hs;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic        in_acc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks;
    int n_errors;

    seq_multiplier_hs #(
        .WIDTH_A (8),
        .WIDTH_B (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
`ifdef SEQ_MULT_ACC_EN
        .in_acc    (in_acc),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one operation, check latency and product; accept if out_ready is high.
    task automatic run_op(input string tag, input logic sgn, input logic [7:0] av,
                          input logic [7:0] bv, input logic accf, input logic [15:0] exp);
        int n;
        int lat;
        in_signed = sgn;
        a         = av;
        b         = bv;
        in_acc    = accf;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_ready_timeout"}, 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        if (out_ready) begin
            tick();
            check({tag, "_accepted"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_acc    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("u5x3", 1'b0, 8'd5, 8'd3, 1'b0, 16'd15);
        run_op("s_m5x3", 1'b1, 8'hFB, 8'h03, 1'b0, 16'hFFF1);
        run_op("s_min_sq", 1'b1, 8'h80, 8'h80, 1'b0, 16'h4000);
        run_op("s127xm127", 1'b1, 8'h7F, 8'h81, 1'b0, 16'hC0FF);
        run_op("uFFxFF", 1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("u10x0", 1'b0, 8'd10, 8'd0, 1'b0, 16'd0);

        // Backpressure: hold DONE for 5 cycles while poking in_valid with other operands.
        out_ready = 1'b0;
        run_op("bp7x9", 1'b0, 8'd7, 8'd9, 1'b0, 16'd63);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 8'd2;
            b        = 8'd2;
            tick();
            check("bp_product", {16'd0, product}, 32'd63);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_product_held", {16'd0, product}, 32'd63);

        // Reset during RUN at counter step 4.
        in_signed = 1'b0;
        a         = 8'd9;
        b         = 8'd9;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("run_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_product", {16'd0, product}, 32'd0);
        run_op("u7x6", 1'b0, 8'd7, 8'd6, 1'b0, 16'd42);

`ifdef SEQ_MULT_ACC_EN
        run_op("acc5x3", 1'b0, 8'd5, 8'd3, 1'b0, 16'd15);
        run_op("acc4x2", 1'b0, 8'd4, 8'd2, 1'b1, 16'd23);
`else
        run_op("plain5x3", 1'b0, 8'd5, 8'd3, 1'b0, 16'd15);
        run_op("plain4x2", 1'b0, 8'd4, 8'd2, 1'b1, 16'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
